// File: rtl/sha_pkg.sv
// Shared SHA-256 types and constants for the message schedule.
package sha_pkg;

  typedef logic [31:0] sha_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  localparam int SHA_PAIRS = 32;
  localparam int SHA_WIN   = 16;

  function automatic sha_word_t bswap32(input sha_word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sigma_small.sv
// SHA-256 small-sigma pair. One instance feeds one new schedule word, which
// needs sigma0 and sigma1 of two different window words, hence two inputs.
module sigma_small
  import sha_pkg::*;
(
  input  sha_word_t x0,
  input  sha_word_t x1,
  output sha_word_t s0,
  output sha_word_t s1
);

  assign s0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
  assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window emitting two W words per step.
// Optional SHA_SCHED_BSWAP_EN byte-reverses each block_in word at load.
module sha_msg_sched
  import sha_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [511:0] block_in,
  input  logic         advance,
  output logic [63:0]  W,
  output logic [5:0]   cycle,
  output logic         valid,
  output logic         done
);

  // Handshake: a pair is offered while valid=1 and is consumed on each
  // rising edge where valid=1 and advance=1; otherwise outputs hold.

  sched_state_t state_q, state_d;
  logic [5:0]   cycle_q, cycle_d;
  sha_word_t    win_q [SHA_WIN];
  sha_word_t    win_d [SHA_WIN];

  sha_word_t s0_a, s1_a, s0_b, s1_b;
  sha_word_t new_a, new_b;

  function automatic sha_word_t load_word(input logic [511:0] blk, input int idx);
    sha_word_t w;
    w = blk[32*(SHA_WIN-1-idx) +: 32];
`ifdef SHA_SCHED_BSWAP_EN
    return bswap32(w);
`else
    return w;
`endif
  endfunction

  sigma_small u_sig_a (
    .x0 (win_q[1]),
    .x1 (win_q[14]),
    .s0 (s0_a),
    .s1 (s1_a)
  );

  sigma_small u_sig_b (
    .x0 (win_q[2]),
    .x1 (win_q[15]),
    .s0 (s0_b),
    .s1 (s1_b)
  );

  // Both new words read only the old window, so they never chain.
  assign new_a = s1_a + win_q[9]  + s0_a + win_q[0];
  assign new_b = s1_b + win_q[10] + s0_b + win_q[1];

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          for (int i = 0; i < SHA_WIN; i++) begin
            win_d[i] = load_word(block_in, i);
          end
          cycle_d = 6'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (advance) begin
          if (cycle_q == 6'(SHA_PAIRS)) begin
            state_d = DONE;
          end else begin
            for (int i = 0; i < SHA_WIN - 2; i++) begin
              win_d[i] = win_q[i+2];
            end
            win_d[14] = new_a;
            win_d[15] = new_b;
            cycle_d   = cycle_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cycle_q <= '0;
      for (int i = 0; i < SHA_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      win_q   <= win_d;
    end
  end

  assign W     = {win_q[1], win_q[0]};
  assign cycle = cycle_q;
  assign valid = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule
